// File: rtl/sobel_line_scheduler.sv
// sobel_line_scheduler: packs 1-bit Sobel pixels into a two-bank line buffer and hands complete lines to the UDP transmitter.
module sobel_line_scheduler #(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 720,
  parameter int LINE_BYTES   = IMAGE_WIDTH / 8
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        valid,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        sobel,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [15:0] tx_line_num,
  input  logic        tx_rd_en,
  output logic [7:0]  tx_rd_data,
  input  logic        tx_done,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);
  localparam int PW = $clog2(IMAGE_WIDTH + 1);
  localparam int AW = $clog2(2 * LINE_BYTES);
  localparam int RW = $clog2(LINE_BYTES + 1);

  if (IMAGE_WIDTH % 8 != 0 || LINE_BYTES != IMAGE_WIDTH / 8 || IMAGE_HEIGHT < 1 || IMAGE_HEIGHT > 65536) begin : g_bad_params
    $error("sobel_line_scheduler: unsupported image geometry");
  end

  typedef enum logic [1:0] {IDLE, START, SEND} state_t;
  state_t state, state_n;

  logic [7:0]    mem [2*LINE_BYTES];
  logic [PW-1:0] pix_cnt;
  logic [6:0]    shift;
  logic          wr_bank, rd_bank, hsync_d, vsync_d;
  logic [1:0]    full;
  logic [15:0]   line_num, full_line;
  logic [RW-1:0] rd_addr;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          accept, complete, short_line, vsync_rise, freed, other_free;

  assign vsync_rise = vsync & ~vsync_d;
  assign accept     = valid & hsync & (pix_cnt < PW'(IMAGE_WIDTH));
  assign complete   = accept & (pix_cnt == PW'(IMAGE_WIDTH - 1));
  assign short_line = hsync_d & ~hsync & (pix_cnt != '0) & (pix_cnt < PW'(IMAGE_WIDTH)) & ~vsync_rise;
  // A bank released this cycle counts as free, so a coinciding completion is kept
  assign freed      = (state == SEND) & tx_done;
  assign other_free = ~full[~wr_bank] | freed;
  assign wr_ptr     = (wr_bank ? AW'(LINE_BYTES) : '0) + AW'(pix_cnt >> 3);
  assign rd_ptr     = (rd_bank ? AW'(LINE_BYTES) : '0) + AW'(rd_addr);
  assign tx_start   = state == START;

  always_ff @(posedge clk)
    if (accept && pix_cnt[2:0] == 3'd7) mem[wr_ptr] <= {shift, sobel};

  always_ff @(posedge clk or posedge rst_p)
    if (rst_p) begin
      hsync_d   <= 1'b0;
      vsync_d   <= 1'b0;
      shift     <= '0;
      pix_cnt   <= '0;
      full      <= '0;
      wr_bank   <= 1'b0;
      full_line <= '0;
      line_num  <= '0;
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      hsync_d <= hsync;
      vsync_d <= vsync;
      if (accept) shift <= {shift[5:0], sobel};
      pix_cnt <= (vsync_rise || (hsync_d && !hsync)) ? '0 : accept ? pix_cnt + 1'b1 : pix_cnt;
      if (freed) full[rd_bank] <= 1'b0;
      if (complete && other_free) begin
        full[wr_bank] <= 1'b1;
        full_line     <= line_num;
        wr_bank       <= ~wr_bank;
      end
      if ((complete && !other_free) || short_line) drop_cnt <= drop_cnt + 1'b1;
      line_num <= vsync_rise ? '0 : (complete || short_line) ? line_num + 1'b1 : line_num;
      if (vsync_rise) frame_cnt <= frame_cnt + 1'b1;
    end

  always_ff @(posedge clk or posedge rst_p)
    if (rst_p) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? ((full[~wr_bank] && tx_ready) ? START : IDLE) :
              (state == START) ? SEND : (tx_done ? IDLE : SEND);
  end

  always_ff @(posedge clk or posedge rst_p)
    if (rst_p) begin
      rd_bank     <= 1'b0;
      rd_addr     <= '0;
      tx_line_num <= '0;
      tx_rd_data  <= '0;
    end else begin
      if (state == IDLE && state_n == START) begin
        rd_bank     <= ~wr_bank;
        tx_line_num <= full_line;
      end
      if (state == START) rd_addr <= '0;
      // Reads past the end of the line return zero and the address saturates
      if (state == SEND && tx_rd_en) begin
        tx_rd_data <= (rd_addr < RW'(LINE_BYTES)) ? mem[rd_ptr] : 8'h00;
        if (rd_addr < RW'(LINE_BYTES)) rd_addr <= rd_addr + 1'b1;
      end
    end
endmodule

// File: tb/tb_sobel_line_scheduler.sv
// tb_sobel_line_scheduler: scoreboard bench driving Sobel lines and a modelled UDP transmitter.
module tb_sobel_line_scheduler;
  logic        clk = 1'b0;
  logic        rst_p, valid, hsync, vsync, sobel, tx_ready, tx_rd_en, tx_done;
  logic        tx_start;
  logic [15:0] tx_line_num, frame_cnt, drop_cnt;
  logic [7:0]  tx_rd_data;
  int          compared = 0;
  int          mismatched = 0;
  int          lines_driven = 0;
  logic [7:0]  q_bytes[$];
  logic [15:0] q_line[$];

  always #5 clk = ~clk;

  sobel_line_scheduler dut (
    .clk(clk), .rst_p(rst_p), .valid(valid), .hsync(hsync), .vsync(vsync), .sobel(sobel),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_line_num(tx_line_num), .tx_rd_en(tx_rd_en),
    .tx_rd_data(tx_rd_data), .tx_done(tx_done), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix_byte(input logic [7:0] seed, input int k);
    return (seed == 8'h00) ? 8'h80 : 8'(int'(seed) + k);
  endfunction

  task automatic do_reset;
    rst_p = 1'b1; valid = 1'b0; hsync = 1'b0; vsync = 1'b0; sobel = 1'b0;
    tx_ready = 1'b1; tx_rd_en = 1'b0; tx_done = 1'b0;
    q_bytes.delete(); q_line.delete(); lines_driven = 0;
    repeat (3) tick;
    rst_p = 1'b0;
    tick;
  endtask

  task automatic frame_start;
    vsync = 1'b1;
    tick; tick;
    vsync = 1'b0;
    tick;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_line(input int n, input logic [7:0] seed, input bit keep, input bit done_on_last, input logic [15:0] lnum);
    logic [7:0] b;
    if (keep) begin
      q_line.push_back(lnum);
      for (int k = 0; k < 160; k++) q_bytes.push_back(pix_byte(seed, k));
    end
    hsync = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = pix_byte(seed, i / 8);
      valid = 1'b1;
      sobel = b[7 - (i % 8)];
      if (done_on_last && i == n - 1) tx_done = 1'b1;
      tick;
    end
    if (done_on_last) tx_done = 1'b0;
    valid = 1'b0; hsync = 1'b0;
    tick; tick;
    lines_driven++;
  endtask

  task automatic rx_line(input int hold_lines, input bit send_done, input int n_reads);
    int n;
    logic [7:0] exp_b;
    logic [15:0] exp_l;
    n = 0;
    while (tx_start !== 1'b1 && n < 5000) begin tick; n++; end
    compared++;
    if (tx_start !== 1'b1) begin
      mismatched++;
      $display("FAIL tx_start_timeout: tx_start=%b expected 1", tx_start);
      return;
    end
    if (q_line.size() > 0) exp_l = q_line.pop_front(); else exp_l = 16'hffff;
    check16("tx_line_num", tx_line_num, exp_l);
    tick;
    check16("tx_start_one_cycle", {15'd0, tx_start}, 16'd0);
    for (int i = 0; i < n_reads; i++) begin
      tx_rd_en = 1'b1;
      tick;
      exp_b = 8'h00;
      if (i < 160 && q_bytes.size() > 0) exp_b = q_bytes.pop_front();
      compared++;
      if (tx_rd_data !== exp_b) begin
        mismatched++;
        $display("FAIL rd_data[%0d] line %0d: got %h expected %h", i, exp_l, tx_rd_data, exp_b);
      end
    end
    tx_rd_en = 1'b0;
    if (hold_lines > 0) begin
      n = 0;
      while (lines_driven < hold_lines && n < 20000) begin tick; n++; end
      check16("hold_timeout", 16'(lines_driven >= hold_lines), 16'd1);
    end
    if (send_done) begin
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
    end
  endtask

  task automatic expect_no_start(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_start === 1'b1) seen++;
      tick;
    end
    check16(name, 16'(seen), 16'd0);
  endtask

  task automatic test_reset;
    rst_p = 1'b1; valid = 1'b0; hsync = 1'b0; vsync = 1'b0; sobel = 1'b0;
    tx_ready = 1'b1; tx_rd_en = 1'b0; tx_done = 1'b0;
    tick; tick;
    check16("reset_tx_start", {15'd0, tx_start}, 16'd0);
    check16("reset_tx_line_num", tx_line_num, 16'd0);
    check16("reset_tx_rd_data", {8'd0, tx_rd_data}, 16'd0);
    check16("reset_frame_cnt", frame_cnt, 16'd0);
    check16("reset_drop_cnt", drop_cnt, 16'd0);
    do_reset;
  endtask

  task automatic test_single_line;
    do_reset;
    frame_start;
    fork
      drive_line(1280, 8'h00, 1'b1, 1'b0, 16'd0);
      rx_line(0, 1'b1, 162);
    join
    expect_no_start("single_extra_start", 50);
    check16("single_frame_cnt", frame_cnt, 16'd1);
    check16("single_drop_cnt", drop_cnt, 16'd0);
  endtask

  task automatic test_back_to_back;
    do_reset;
    frame_start;
    fork
      begin
        drive_line(1280, 8'h11, 1'b1, 1'b0, 16'd0);
        drive_line(1280, 8'h22, 1'b1, 1'b0, 16'd1);
        drive_line(1280, 8'h33, 1'b0, 1'b0, 16'd2);
      end
      begin
        rx_line(0, 1'b1, 162);
        rx_line(3, 1'b1, 162);
      end
    join
    expect_no_start("b2b_dropped_line_sent", 100);
    check16("b2b_drop_cnt", drop_cnt, 16'd1);
  endtask

  task automatic test_done_collision;
    do_reset;
    frame_start;
    fork
      begin
        drive_line(1280, 8'h44, 1'b1, 1'b0, 16'd0);
        drive_line(1280, 8'h55, 1'b1, 1'b1, 16'd1);
      end
      begin
        rx_line(0, 1'b0, 162);
        rx_line(0, 1'b1, 162);
      end
    join
    check16("collision_drop_cnt", drop_cnt, 16'd0);
  endtask

  task automatic test_short_line;
    do_reset;
    frame_start;
    fork
      begin
        drive_line(1000, 8'h66, 1'b0, 1'b0, 16'd0);
        drive_line(1280, 8'h77, 1'b1, 1'b0, 16'd1);
      end
      rx_line(0, 1'b1, 162);
    join
    check16("short_drop_cnt", drop_cnt, 16'd1);
  endtask

  task automatic test_vsync_mid_line;
    do_reset;
    frame_start;
    fork
      begin
        for (int l = 0; l < 5; l++) drive_line(1280, 8'(8'h10 * (l + 1) + 3), 1'b1, 1'b0, 16'(l));
        hsync = 1'b1;
        for (int i = 0; i < 500; i++) begin valid = 1'b1; sobel = 1'($urandom_range(1)); tick; end
        valid = 1'b0; vsync = 1'b1;
        tick;
        hsync = 1'b0;
        tick;
        vsync = 1'b0;
        tick;
        lines_driven++;
        drive_line(1280, 8'h9a, 1'b1, 1'b0, 16'd0);
      end
      begin
        for (int l = 0; l < 4; l++) rx_line(0, 1'b1, 162);
        rx_line(6, 1'b1, 162);
        rx_line(0, 1'b1, 162);
      end
    join
    check16("vsync_frame_cnt", frame_cnt, 16'd2);
    check16("vsync_drop_cnt", drop_cnt, 16'd0);
  endtask

  task automatic test_reset_mid_send;
    do_reset;
    frame_start;
    fork
      begin
        drive_line(16, 8'h21, 1'b0, 1'b0, 16'd0);
        drive_line(1280, 8'h31, 1'b1, 1'b0, 16'd1);
      end
      rx_line(0, 1'b0, 50);
    join
    check16("pre_reset_drop_cnt", drop_cnt, 16'd1);
    rst_p = 1'b1;
    #2;
    check16("async_tx_start", {15'd0, tx_start}, 16'd0);
    check16("async_tx_line_num", tx_line_num, 16'd0);
    check16("async_tx_rd_data", {8'd0, tx_rd_data}, 16'd0);
    check16("async_frame_cnt", frame_cnt, 16'd0);
    check16("async_drop_cnt", drop_cnt, 16'd0);
    q_bytes.delete(); q_line.delete(); lines_driven = 0;
    tick;
    rst_p = 1'b0;
    tick;
    fork
      drive_line(1280, 8'h47, 1'b1, 1'b0, 16'd0);
      rx_line(0, 1'b1, 162);
    join
    check16("post_reset_frame_cnt", frame_cnt, 16'd0);
  endtask

  initial begin
    test_reset;
    test_single_line;
    test_back_to_back;
    test_done_collision;
    test_short_line;
    test_vsync_mid_line;
    test_reset_mid_send;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sobel_line_scheduler.md
Name: sobel_line_scheduler

Overview:
- Sits between the Sobel edge stage and the UDP transmit path, in the twice-divided pixel clock domain.
- Packs the 1-bit Sobel pixels into bytes and stores them in a two-bank line buffer.
- Hands each complete line to the UDP transmitter as one payload with a 16-bit line number, and drops lines when no bank is free.
- Reports frame and drop counts for debug.

Parameters:
- IMAGE_WIDTH, 1280: pixels per line; must be a multiple of 8.
- IMAGE_HEIGHT, 720: lines per frame; used only for the line-number range check.
- LINE_BYTES, IMAGE_WIDTH/8: packed bytes per line (160 at default).

Ports:
- clk  in  1: twice-divided pixel clock; the only clock.
- rst_p  in  1: asynchronous reset, active-high.
- valid  in  1: Sobel pixel valid.
- hsync  in  1: Sobel line sync; high for the whole active line.
- vsync  in  1: Sobel frame sync; rising edge starts a frame.
- sobel  in  1: edge pixel.
- tx_ready  in  1: UDP transmitter idle.
- tx_start  out  1: one-cycle request to send a line.
- tx_line_num  out  16: line number of the bank being sent; stable from tx_start until tx_done.
- tx_rd_en  in  1: transmitter byte read strobe.
- tx_rd_data  out  8: payload byte; valid 1 cycle after tx_rd_en.
- tx_done  in  1: one-cycle pulse when the transmitter has finished the line.
- frame_cnt  out  16: vsync rising edges seen; wraps.
- drop_cnt  out  16: lines discarded; wraps.

Behaviour:
- Reset (async, rst_p=1):
  - All outputs 0; both banks free; write bank 0.
  - Bit, byte and line counters 0; transmit FSM in IDLE.
- Packing:
  - Each valid=1 cycle shifts sobel into a byte, MSB first (first pixel = bit 7).
  - The 8th bit writes the byte to write_bank[byte_idx]; byte_idx increments.
  - valid with hsync=0 is ignored.
- Line completion (IMAGE_WIDTH valid pixels packed):
  - If the other bank is free: mark the write bank full, latch its line_num, switch the write bank.
  - Otherwise: the write bank stays current and is overwritten by the next line; drop_cnt+1.
  - line_num increments in both cases.
- Short line (hsync falling edge with 0 < pixel count < IMAGE_WIDTH):
  - Partial data discarded; drop_cnt+1; line_num+1; counters cleared.
- Extra valid pixels after completion and before the hsync fall are ignored.
- vsync rising edge:
  - frame_cnt+1; line_num←0; bit/byte counters cleared; any partial line discarded without counting as a drop.
  - A bank already full or being sent is unaffected.
- line_num beyond IMAGE_HEIGHT-1 (a missing vsync) keeps counting; 16-bit wrap.
- Transmit FSM states: IDLE, START, SEND.
  - IDLE: if a full bank exists and tx_ready=1 → latch rd_bank and tx_line_num, go to START.
  - START: tx_start=1 for exactly one cycle; rd_addr←0; go to SEND.
  - SEND: each tx_rd_en cycle outputs rd_bank[rd_addr] on tx_rd_data the next cycle, then rd_addr+1.
  - SEND, reads past LINE_BYTES-1: return 0x00 and rd_addr holds.
  - SEND, tx_done: free rd_bank, go to IDLE. tx_done in IDLE or START is ignored.
- At most one bank is full at a time: the write bank is never full. Lines are therefore sent in capture order.
- Simultaneous events:
  - tx_done in the same cycle as line completion: the free takes effect first, so the line is kept with no drop.
  - vsync rise in the same cycle as line completion: the completion is processed with the old line_num, then line_num←0.
- Reset mid-transfer: everything returns to the reset state immediately; the transmitter is expected to abort on the same reset.
- Line buffer: 2×LINE_BYTES×8 RAM with one write port and one registered read port.

Test Plan:
- vsync pulse, then 1280 valid pixels with pattern 1000_0000 repeated, tx_ready=1:
  - one tx_start, tx_line_num=0.
  - 160 reads all return 0x80.
  - tx_done → IDLE; frame_cnt=1, drop_cnt=0.
- Three back-to-back lines, tx_ready=1, transmitter holds tx_done until line 2 has fully arrived:
  - line 0 sent, line 1 queued, line 2 dropped (drop_cnt=1).
  - The next tx_start carries line_num 1.
- tx_done asserted in the same cycle as line 1 completes → line 1 kept; drop_cnt=0; next tx_start has tx_line_num=1.
- Line ends by hsync fall after 1000 pixels → no tx_start for it; drop_cnt=1; the following full line is sent with line_num 1.
- vsync rise after 500 pixels of line 5 while line 4 is in SEND:
  - line 4 finishes normally.
  - The next full line is sent as line_num 0; frame_cnt=2.
- Assert rst_p during SEND at rd_addr=50:
  - tx_start/tx_line_num/tx_rd_data/counters are 0 asynchronously.
  - After release the next line is captured into bank 0 and sent with line_num 0.
